// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;

    // Pause is E1 followed by seven further bytes that must not produce events.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard status/response bytes that carry no key information on their own.
    function automatic logic is_noise(input logic [7:0] b);
        return b inside {8'h00, PS2_BAT, 8'hEE, PS2_ACK, 8'hFC, 8'hFE, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// Key-event bus from the PS/2 decoder to the keyboard matrix block.
interface ps2_kbd_decoder_if;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    modport master (output key_strobe, key_pressed, key_extended, key_code, frame_err);
    modport slave  (input  key_strobe, key_pressed, key_extended, key_code, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines, debounces ps2_clk and emits a one-cycle pulse
// on each falling edge of the filtered clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          filt_clk;
    logic [CW-1:0] stable_cnt;

    // Lines idle high, so the synchronisers and filter come out of reset high
    // and no spurious edge is seen after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            filt_clk   <= 1'b1;
            stable_cnt <= '0;
            fall       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading the pre-edge value of the others.
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            fall     <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                filt_clk   <= clk_sync[1];
                stable_cnt <= '0;
                fall       <= filt_clk;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan-code set 2 receiver: frames bytes, folds E0/F0 prefixes into flags,
// swallows Pause and status bytes, and emits single-cycle key events.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 48000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_kbd_decoder_if.master  kbd
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          fall;
    logic          data_bit;
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tcnt;
    logic          ext_q;
    logic          rel_q;
    logic [2:0]    skip_q;
    logic          strobe_q;
    logic          pressed_q;
    logic          extended_q;
    logic [7:0]    code_q;
    logic          err_q;
    logic          frame_ok;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .fall      (fall),
        .data_sync (data_bit)
    );

    // Stop bit high and odd parity over data plus parity bit.
    assign frame_ok = data_bit & (^shift_q ^ parity_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tcnt       <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
            strobe_q   <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            code_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            // A stalled frame is aborted before any fall in the same cycle is considered.
            if (state != ST_IDLE && tcnt == TW'(TIMEOUT)) begin
                state <= ST_IDLE;
                tcnt  <= '0;
                err_q <= 1'b1;
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (fall) begin
                tcnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        if (!data_bit) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {data_bit, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_q <= data_bit;
                        state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!frame_ok) begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                        end else if (skip_q != 3'd0) begin
                            skip_q <= skip_q - 3'd1;
                        end else if (shift_q == PS2_PAUSE) begin
                            skip_q <= PAUSE_SKIP;
                        end else if (shift_q == PS2_EXT) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == PS2_REL) begin
                            rel_q <= 1'b1;
                        end else if (ext_q || rel_q || !is_noise(shift_q)) begin
                            strobe_q   <= 1'b1;
                            code_q     <= shift_q;
                            pressed_q  <= ~rel_q;
                            extended_q <= ext_q;
                            ext_q      <= 1'b0;
                            rel_q      <= 1'b0;
                        end
                    end
                endcase
            end else if (state != ST_IDLE) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign kbd.key_strobe   = strobe_q;
    assign kbd.key_pressed  = pressed_q;
    assign kbd.key_extended = extended_q;
    assign kbd.key_code     = code_q;
    assign kbd.frame_err    = err_q;

endmodule
